// File: rtl/mbist_march_engine.sv
// March test engine: issues a 4-element March sequence to a single-port RAM and compares the read data.
// Optional MBIST_CHECKERBOARD_EN selects an address-dependent checkerboard background instead of all zeros.
module mbist_march_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              NbarT,
  output logic              cout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [ADDR_W-1:0] AMAX = '1;

  typedef enum logic [1:0] {RUN, FIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                op_q, op_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   bg;
  logic                active;

  // D0 background for the current address; D1 is always its inverse.
`ifdef MBIST_CHECKERBOARD_EN
  always_comb begin
    bg = '0;
    for (int i = 0; i < DATA_W; i++) bg[i] = ((i % 2) == 0) ^ addr_q[0];
  end
`else
  assign bg = '0;
`endif

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign active    = NbarT & ~ld & ~rst;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    op_d        = op_q;
    cmp_vld_d   = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    cout        = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    // A read issued last cycle is judged even while paused or reloading.
    if (cmp_vld_q && (mem_rdata != cmp_exp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = cmp_addr_q;
    end

    if (ld) begin
      state_d = RUN;
      elem_d  = 2'd0;
      addr_d  = '0;
      op_d    = 1'b0;
    end else if (active) begin
      unique case (state_q)
        RUN: begin
          mem_addr = addr_q;
          unique case (elem_q)
            2'd0: begin
              mem_we    = 1'b1;
              mem_wdata = bg;
              if (addr_q == '0) begin
                fail_d      = 1'b0;
                fail_addr_d = '0;
              end
              if (addr_q == AMAX) begin
                elem_d = 2'd1;
                addr_d = '0;
              end else addr_d = addr_q + 1'b1;
            end
            2'd1: begin
              if (!op_q) begin
                mem_re    = 1'b1;
                cmp_exp_d = bg;
                op_d      = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_wdata = ~bg;
                op_d      = 1'b0;
                if (addr_q == AMAX) elem_d = 2'd2;
                else addr_d = addr_q + 1'b1;
              end
            end
            2'd2: begin
              if (!op_q) begin
                mem_re    = 1'b1;
                cmp_exp_d = ~bg;
                op_d      = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_wdata = bg;
                op_d      = 1'b0;
                if (addr_q == '0) begin
                  elem_d = 2'd3;
                  addr_d = AMAX;
                end else addr_d = addr_q - 1'b1;
              end
            end
            default: begin
              mem_re    = 1'b1;
              cmp_exp_d = bg;
              if (addr_q == '0) state_d = FIN;
              else addr_d = addr_q - 1'b1;
            end
          endcase
          if (mem_re) begin
            cmp_vld_d  = 1'b1;
            cmp_addr_d = addr_q;
          end
        end
        FIN: begin
          cout    = 1'b1;
          state_d = DONE;
        end
        default: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      elem_q      <= 2'd0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

endmodule

// File: tb/tb_mbist_march_engine.sv
// Scoreboard bench for mbist_march_engine: op-list reference model, faulty RAM model, per-cycle output checks.
module tb_mbist_march_engine;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;
  localparam int L  = 6 * N;

  logic          clk = 1'b0;
  logic          rst, ld, NbarT;
  logic          cout, mem_we, mem_re, fail;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mbist_march_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ld(ld), .NbarT(NbarT), .cout(cout),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .fail(fail), .fail_addr(fail_addr)
  );

  // RAM under test with one optional stuck-at-1 fault
  logic [DW-1:0] ram [N];
  logic          fault_en;
  logic [AW-1:0] fault_addr;
  logic [DW-1:0] fault_mask;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr] | ((fault_en && mem_addr == fault_addr) ? fault_mask : '0);
  end

  typedef struct packed {
    logic          we, re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          cout, fail;
    logic [AW-1:0] faddr;
  } obs_t;

  obs_t expq[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference: the whole March sequence as a flat list of ops
  logic          o_we   [L];
  logic [AW-1:0] o_addr [L];
  logic [DW-1:0] o_data [L];

  function automatic logic [DW-1:0] bgf(input int a);
`ifdef MBIST_CHECKERBOARD_EN
    return (a % 2 == 0) ? 8'h55 : 8'hAA;
`else
    return (a < 0) ? 8'hFF : 8'h00;
`endif
  endfunction

  task automatic add_op(inout int k, input logic w, input int a, input logic [DW-1:0] d);
    o_we[k] = w; o_addr[k] = AW'(a); o_data[k] = d; k++;
  endtask

  task automatic build_ops();
    int k = 0;
    for (int a = 0; a < N; a++) add_op(k, 1'b1, a, bgf(a));
    for (int a = 0; a < N; a++) begin add_op(k, 1'b0, a, bgf(a)); add_op(k, 1'b1, a, ~bgf(a)); end
    for (int a = N - 1; a >= 0; a--) begin add_op(k, 1'b0, a, ~bgf(a)); add_op(k, 1'b1, a, bgf(a)); end
    for (int a = N - 1; a >= 0; a--) add_op(k, 1'b0, a, bgf(a));
  endtask

  int            idx;
  bit            fail_m, pend_mis;
  logic [AW-1:0] faddr_m, pend_addr;

  // One wall cycle: drive controls, push expected outputs, advance the model.
  task automatic step(input bit r, input bit act, input bit ldv);
    obs_t          e;
    bit            nmis;
    logic [AW-1:0] naddr;
    int            i0;
    rst   = r;
    ld    = ldv;
    NbarT = ldv ? 1'($urandom_range(0, 1)) : act;
    e = '0; nmis = 0; naddr = '0;
    if (r) begin
      idx = 0; fail_m = 0; faddr_m = '0; pend_mis = 0;
      expq.push_back(e);
    end else begin
      e.fail = fail_m; e.faddr = faddr_m; i0 = idx;
      if (ldv) idx = 0;
      else if (act) begin
        if (idx < L) begin
          e.we = o_we[idx]; e.re = !o_we[idx]; e.addr = o_addr[idx];
          e.wd = o_we[idx] ? o_data[idx] : '0;
          if (e.re && fault_en && o_addr[idx] == fault_addr && (o_data[idx] | fault_mask) != o_data[idx]) nmis = 1;
          naddr = o_addr[idx];
          idx++;
        end else if (idx == L) begin
          e.cout = 1'b1; idx++;
        end
      end
      expq.push_back(e);
      if (!ldv && act && i0 == 0) begin
        fail_m = 0; faddr_m = '0;
      end else if (pend_mis) begin
        if (!fail_m) faddr_m = pend_addr;
        fail_m = 1;
      end
      pend_mis = nmis; pend_addr = naddr;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_active(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0);
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {mem_we, mem_re, mem_addr, mem_wdata, cout, fail, fail_addr};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle %0d: got we=%0b re=%0b addr=%0d wd=%h cout=%0b fail=%0b faddr=%0d, want we=%0b re=%0b addr=%0d wd=%h cout=%0b fail=%0b faddr=%0d",
                 cyc, a.we, a.re, a.addr, a.wd, a.cout, a.fail, a.faddr,
                 e.we, e.re, e.addr, e.wd, e.cout, e.fail, e.faddr);
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1; ld = 1'b1; NbarT = 1'b0;
    fault_en = 1'b0; fault_addr = '0; fault_mask = '0;
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
    build_ops();
    @(posedge clk); #1;

    // reset, then idle under ld
    step(1, 0, 1); step(1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1);

    // fault-free complete run plus DONE hold
    step(0, 0, 1); run_active(100);

    // stuck-at-1 on bit 3 of address 5
    fault_en = 1'b1; fault_addr = 4'd5; fault_mask = 8'h08;
    step(0, 0, 1); run_active(100);

    // abort at t=40 and restart
    fault_en = 1'b0;
    step(0, 0, 1); run_active(40); step(0, 0, 1); run_active(100);

    // pause of 3 cycles at t=60
    step(0, 0, 1); run_active(60);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    run_active(40);

    // reset mid-run with a fault present, then restart straight from reset
    fault_en = 1'b1; fault_addr = 4'd2; fault_mask = 8'h01;
    step(0, 0, 1); run_active(30); step(1, 1, 0); run_active(100);

    // randomized faults, pauses and occasional aborts
    for (int run = 0; run < 5; run++) begin
      fault_en   = 1'($urandom_range(0, 1));
      fault_addr = AW'($urandom_range(0, N - 1));
      fault_mask = DW'(1 << $urandom_range(0, DW - 1));
      step(0, 0, 1);
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 99);
        if (r < 20) step(0, 0, 0);
        else if (r == 99) step(0, 0, 1);
        else step(0, 1, 0);
      end
    end

    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
